// File: rtl/logic_gate_pkg.sv
// Shared constants for the handshaked six-gate logic unit: gate indices, delivery
// modes and FSM state encodings.
package logic_gate_pkg;

    localparam int NUM_GATES = 6;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam logic MODE_PAR   = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/gate_lanes.sv
// Combinational bitwise evaluation of all six gates, packed so that slice k
// holds gate k (the legacy door bus order when WIDTH is 1).
module gate_lanes
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [NUM_GATES*WIDTH-1:0] lanes
);

    always_comb begin
        lanes = '0;
        lanes[int'(OP_AND)*WIDTH  +: WIDTH] = a & b;
        lanes[int'(OP_OR)*WIDTH   +: WIDTH] = a | b;
        lanes[int'(OP_NAND)*WIDTH +: WIDTH] = ~(a & b);
        lanes[int'(OP_NOR)*WIDTH  +: WIDTH] = ~(a | b);
        lanes[int'(OP_XOR)*WIDTH  +: WIDTH] = a ^ b;
        lanes[int'(OP_XNOR)*WIDTH +: WIDTH] = ~(a ^ b);
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registers all six gate results of an accepted operand pair and delivers them as
// one packed beat (parallel) or six single-gate beats (sweep), valid/ready on both sides.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 op,
    output logic [WIDTH-1:0]           y,
    output logic                       last,
    output logic [NUM_GATES*WIDTH-1:0] cout
);

    // Handshake: a transfer happens on a rising edge where valid && ready; a source
    // holds its data until then, and a held output beat stays stable while stalled.
    logic [0:0]                 state;
    logic [2:0]                 op_q;
    logic                       mode_q;
    logic [NUM_GATES*WIDTH-1:0] cout_q;
    logic [NUM_GATES*WIDTH-1:0] lanes;
    logic                       busy;
    logic                       fire_in;
    logic                       fire_out;

    gate_lanes #(.WIDTH(WIDTH)) u_lanes (
        .a     (a),
        .b     (b),
        .lanes (lanes)
    );

    assign busy      = (state == ST_BUSY);
    assign out_valid = busy;
    assign last      = busy && ((mode_q == MODE_PAR) || (op_q == OP_XNOR));
    // Accepting while the final beat drains keeps pairs back-to-back.
    assign in_ready  = !busy || (last && out_ready);
    assign fire_in   = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_AND;
            mode_q <= MODE_PAR;
            cout_q <= '0;
        end else if (fire_in) begin
            state  <= ST_BUSY;
            op_q   <= OP_AND;
            mode_q <= mode;
            cout_q <= lanes;
        end else if (fire_out) begin
            if (last) begin
                state <= ST_IDLE;
            end else begin
                op_q <= op_q + 3'd1;
            end
        end
    end

    always_comb begin
        y = '0;
        for (int k = 0; k < NUM_GATES; k++) begin
            if (op_q == 3'(k)) begin
                y = cout_q[k*WIDTH +: WIDTH];
            end
        end
    end

    assign op   = op_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: a WIDTH=4 instance checked every cycle against a beat-queue
// model, plus a WIDTH=1 instance driven with the door truth table.
module tb_logic_gate_unit;

  localparam int W4 = 4;
  localparam int BW = 1 + 3 + W4 + 6 * W4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=4 instance
  logic           in_valid4 = 1'b0;
  logic           in_ready4;
  logic [W4-1:0]  a4 = '0;
  logic [W4-1:0]  b4 = '0;
  logic           mode4 = 1'b0;
  logic           out_valid4;
  logic           out_ready4 = 1'b1;
  logic [2:0]     op4;
  logic [W4-1:0]  y4;
  logic           last4;
  logic [6*W4-1:0] cout4;

  // WIDTH=1 instance
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       mode1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [2:0] op1;
  logic [0:0] y1;
  logic       last1;
  logic [5:0] cout1;

  logic_gate_unit #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .op(op4), .y(y4), .last(last4), .cout(cout4)
  );

  logic_gate_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .mode(mode1), .out_valid(out_valid1), .out_ready(out_ready1),
    .op(op1), .y(y1), .last(last1), .cout(cout1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready pattern: 0 = always 1, 1 = random, 2 = 1,0,0 repeating
  int rdy_mode = 0;
  int pat_cnt  = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready4 = 1'b1;
      1: out_ready4 = 1'($urandom_range(0, 1));
      default: begin
        out_ready4 = (pat_cnt % 3 == 0);
        pat_cnt++;
      end
    endcase
  end

  // scoreboard: queue of beats {last, op, y, cout} still owed for the current pair
  logic [BW-1:0]   exp_q[$];
  logic            fire_in_n  = 1'b0;
  logic            fire_out_n = 1'b0;
  logic            exp_ir;
  logic [W4-1:0]   a_s, b_s;
  logic            m_s;
  logic [W4-1:0]   g[6];
  logic [6*W4-1:0] c_s;

  always @(negedge clk) begin
    fire_in_n  = 1'b0;
    fire_out_n = 1'b0;
    if (!rst) begin
      exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready4);
      chk("out_valid", 64'(out_valid4), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready4), 64'(exp_ir));
      if (out_valid4 && exp_q.size() != 0)
        chk("beat", 64'({last4, op4, y4, cout4}), 64'(exp_q[0]));
      fire_out_n = (exp_q.size() != 0) && out_ready4;
      fire_in_n  = in_valid4 && exp_ir;
      a_s = a4;
      b_s = b4;
      m_s = mode4;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (fire_out_n) void'(exp_q.pop_front());
      if (fire_in_n) begin
        g[0] = a_s & b_s;
        g[1] = a_s | b_s;
        g[2] = ~(a_s & b_s);
        g[3] = ~(a_s | b_s);
        g[4] = a_s ^ b_s;
        g[5] = ~(a_s ^ b_s);
        c_s = {g[5], g[4], g[3], g[2], g[1], g[0]};
        if (!m_s) exp_q.push_back({1'b1, 3'd0, g[0], c_s});
        else
          for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), 3'(k), g[k], c_s});
      end
    end
  end

  // driver: offer one pair on the WIDTH=4 instance and hold it until accepted
  task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic m);
    int t;
    t = 0;
    a4 = a;
    b4 = b;
    mode4 = m;
    in_valid4 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready4) break;
      t++;
      if (t > 100) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
  endtask

  task automatic drain4();
    int t;
    t = 0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0]    door_tbl[4] = '{6'b101100, 6'b010110, 6'b010110, 6'b100011};
  logic [W4-1:0] sweep_y[6]  = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

  initial begin
    // reset values while reset is held
    #1;
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_op", 64'(op4), 64'd0);
    chk("rst_y", 64'(y4), 64'd0);
    chk("rst_last", 64'(last4), 64'd0);
    chk("rst_cout4", 64'(cout4), 64'd0);
    chk("rst_cout1", 64'(cout1), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // WIDTH=1 door table, parallel, back-to-back
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      in_valid1 = 1'b1;
      @(negedge clk);
      chk("w1_in_ready", 64'(in_ready1), 64'd1);
      if (i > 0) begin
        chk("w1_cout", 64'(cout1), 64'(door_tbl[i-1]));
        chk("w1_last", 64'(last1), 64'd1);
        chk("w1_valid", 64'(out_valid1), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_cout", 64'(cout1), 64'(door_tbl[3]));
    chk("w1_op", 64'(op1), 64'd0);
    chk("w1_y", 64'(y1), 64'd1);
    @(negedge clk);
    chk("w1_idle", 64'(out_valid1), 64'd0);
    @(posedge clk);
    #1;

    // WIDTH=4 sweep, literal beats
    send4(4'b1100, 4'b1010, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sw_op", 64'(op4), 64'(i));
      chk("sw_y", 64'(y4), 64'(sweep_y[i]));
      chk("sw_last", 64'(last4), 64'(i == 5));
      chk("sw_in_ready", 64'(in_ready4), 64'(i == 5));
    end
    @(posedge clk);
    #1;

    // sweep followed by a parallel pair offered during the sweep
    send4(4'b1100, 4'b1010, 1'b1);
    send4(4'b0011, 4'b0101, 1'b0);
    @(negedge clk);
    chk("b2b_op", 64'(op4), 64'd0);
    chk("b2b_last", 64'(last4), 64'd1);
    chk("b2b_cout", 64'(cout4), 64'h968E71);
    drain4();

    // sweep under a 1,0,0 out_ready pattern
    pat_cnt = 0;
    rdy_mode = 2;
    send4(4'b0110, 4'b0011, 1'b1);
    repeat (25) @(posedge clk);
    #1;
    drain4();

    // reset during beat 2 of a sweep
    send4(4'b1100, 4'b1010, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_op", 64'(op4), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid4), 64'd0);
    chk("mid_rst_cout", 64'(cout4), 64'd0);
    chk("mid_rst_op", 64'(op4), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 64'(in_ready4), 64'd1);
    @(posedge clk);
    #1;

    // randomized pairs, modes, gaps and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, handshaked successor to the six-gate `door` block. It evaluates AND, OR, NAND, NOR, XOR and XNOR bitwise on two WIDTH-bit operands, and registers the results. It delivers them either as one packed beat (parallel mode) or as six sequential single-gate beats (sweep mode). It sits between an operand source and a consumer, both using valid/ready flow control.

## Interface
- `WIDTH`, default 1: operand width in bits. Must be 1 or more.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset; asynchronous, active-high.
- `in_valid`  in  1  — operand pair on `a`/`b`/`mode` is valid.
- `in_ready`  out  1  — unit can accept a pair this cycle.
- `a`  in  WIDTH  — operand A.
- `b`  in  WIDTH  — operand B.
- `mode`  in  1  — 0 = parallel (one beat), 1 = sweep (six beats). Sampled only at accept.
- `out_valid`  out  1  — output beat valid.
- `out_ready`  in  1  — consumer takes the beat this cycle.
- `op`  out  3  — gate index of the current beat: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
- `y`  out  WIDTH  — result of gate `op`.
- `last`  out  1  — final beat for the current operand pair.
- `cout`  out  6*WIDTH  — all six results packed as `cout[k*WIDTH +: WIDTH]` = gate k. For WIDTH=1 this is the 6-bit `door` bus order.

## Operation
- States:
  - IDLE: no beat held.
  - BUSY: beat held on the outputs.
- Accept happens on a rising edge where `in_valid && in_ready`.
  - Operands and mode are captured.
  - All six results are computed from the captured operands and registered into `cout`.
  - `op` is set to 0 and the state goes to BUSY.
- Parallel mode: exactly one beat, with `op`=0, `y`=AND and `last`=1.
- Sweep mode: six beats, with `op` = 0,1,2,3,4,5 in order. `last`=1 only on `op`=5.
  - `op` advances only on a consumed beat (`out_valid && out_ready`).
- A consumed beat with `last`=1 ends the pair.
  - If a new pair is accepted in the same cycle, the unit stays BUSY with the new pair's beat 0.
  - Otherwise it returns to IDLE.
- `in_ready` = IDLE, or (BUSY and `last` and `out_ready`). This gives back-to-back pairs with no bubble.
- Stall: while `out_valid && !out_ready`, the values of `op`, `y`, `last` and `cout` are held stable.
- `cout` stays constant for all beats of a sweep.
- `y` is selected combinationally from registered `cout` by registered `op`. It contains no input-to-output combinational path.

## Timing
- Reset (asynchronous, immediate): state IDLE, `out_valid`=0, `op`=0, `y`=0, `last`=0, `cout`=0, captured operands=0.
  - `in_ready`=1 from the first edge after `rst` falls.
- Latency: an accept at edge N gives `out_valid`=1 after edge N, i.e. one cycle.
- Throughput:
  - Parallel mode: one pair per cycle with `out_ready` held high.
  - Sweep mode: one pair per six cycles.
- Reset asserted mid-sweep: the partial sweep is discarded and the outputs take their reset values immediately. No further beats of that pair appear.
- `in_valid` with `in_ready`=0: no capture. The source holds its data, and the unit does not drop it.
- `op` never exceeds 5. The counter wraps to 0 only via a new accept.

## Structure
- Shared package `logic_gate_pkg`:
  - `NUM_GATES`=6.
  - Gate index constants `OP_AND`..`OP_XNOR` (0..5).
  - Mode constants `MODE_PAR`=0, `MODE_SWEEP`=1.
- Sub-module `gate_lanes` (combinational, parameter WIDTH): inputs `a`/`b`, output packed six-gate vector in the `cout` order.
- Top level holds:
  - the FSM;
  - the `op` counter;
  - the mode register;
  - the `cout` register;
  - the `y` mux.

## Test plan
- WIDTH=1, parallel mode, with `out_ready`=1, driving the pairs in the following order:

  | a | b | required `cout` |
  |---|---|---|
  | 0 | 0 | 6'b101100 |
  | 0 | 1 | 6'b010110 |
  | 1 | 0 | 6'b010110 |
  | 1 | 1 | 6'b100011 |

  - Pairs are driven back-to-back, and each `cout` appears one cycle after its accept.
  - `last`=1 on every beat, and there are no idle cycles.
- WIDTH=4, sweep mode, `a`=4'b1100, `b`=4'b1010, `out_ready`=1:
  - `y` over the six beats is 1000, 1110, 0111, 0001, 0110, 1001, with `op` 0→5.
  - `last` is asserted only on beat 5.
  - `in_ready` is 0 during beats 0–4.
- Sweep with `out_ready` toggled 1,0,0,1…: `op` and `y` are held during stalls, and no beat is skipped or duplicated.
- Sweep pair followed by a parallel pair offered while beat 5 is consumed: the new pair is accepted in that same cycle, and the next cycle shows `op`=0, `last`=1 with the new `cout`.
- Assert `rst` during beat 2 of a sweep: `out_valid` and `cout` drop to 0 immediately, and after release `in_ready`=1 with no stale beats.
